// File: rtl/cla_pkg.sv
// Shared definitions for the CLA restoring divider: default width, FSM encoding
// and the iteration counter width.
package cla_pkg;

  localparam int CLA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/cla_subtractor.sv
// N-bit a - b computed as a + ~b + 1 with a Kogge-Stone carry-lookahead network.
// carry_out high means no borrow (a >= b as unsigned).
module cla_subtractor #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] difference,
  output logic         carry_out
);

  logic [N-1:0] b_inv, p, g, gg, pp, gn, pn, carry;

  always_comb begin
    b_inv = ~b;
    p     = a ^ b_inv;
    g     = a & b_inv;
    gn    = '0;
    pn    = '0;
    // carry_in = 1 folds into the bit-0 generate term
    gg    = g;
    gg[0] = g[0] | p[0];
    pp    = p;
    for (int d = 1; d < N; d = d * 2) begin
      gn = gg;
      pn = pp;
      for (int i = d; i < N; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      gg = gn;
      pp = pn;
    end
    carry      = {gg[N-2:0], 1'b1};
    difference = p ^ carry;
    carry_out  = gg[N-1];
  end

endmodule

// File: rtl/cla_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, CLA trial subtraction.
// Optional two's-complement operation is enabled by defining CLA_DIV_SIGNED_EN.
module cla_restoring_divider
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [WIDTH-1:0] num_in, den_in, src_r, src_q, src_d;
  logic [WIDTH-1:0] q_nxt, fin_q, fin_r;
  logic [WIDTH:0]   s, t, r_nxt;
  logic             carry_out, borrow, accept, div_zero_in, last_step;
  logic             unused_r_msb;

`ifdef CLA_DIV_SIGNED_EN
  logic q_neg, r_neg;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  assign num_in = dividend[WIDTH-1] ? negate(dividend) : dividend;
  assign den_in = divisor[WIDTH-1]  ? negate(divisor)  : divisor;
  assign fin_q  = q_neg ? negate(q_nxt) : q_nxt;
  assign fin_r  = r_neg ? negate(r_nxt[WIDTH-1:0]) : r_nxt[WIDTH-1:0];
`else
  assign num_in = dividend;
  assign den_in = divisor;
  assign fin_q  = q_nxt;
  assign fin_r  = r_nxt[WIDTH-1:0];
`endif

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign div_zero_in = (divisor == '0);
  assign last_step   = (state == RUN) && (count == CNT_W'(1));

  // The accepting cycle already performs the first step straight from the
  // operand inputs, so the result lands exactly WIDTH edges after accept.
  assign src_r = (state == IDLE) ? '0     : r_q;
  assign src_q = (state == IDLE) ? num_in : q_q;
  assign src_d = (state == IDLE) ? den_in : d_q;

  assign s = {src_r, src_q[WIDTH-1]};

  cla_subtractor #(
    .N(WIDTH + 1)
  ) u_sub (
    .a         (s),
    .b         ({1'b0, src_d}),
    .difference(t),
    .carry_out (carry_out)
  );

  assign borrow       = ~carry_out;
  assign r_nxt        = borrow ? s : t;
  assign q_nxt        = {src_q[WIDTH-2:0], ~borrow};
  assign unused_r_msb = r_nxt[WIDTH];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = div_zero_in ? DONE : RUN;
      RUN:     if (count == CNT_W'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (div_zero_in) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end else begin
          count       <= CNT_W'(WIDTH - 1);
          div_by_zero <= 1'b0;
        end
      end else if (state == RUN) begin
        count <= count - CNT_W'(1);
      end
      if (last_step) begin
        quotient  <= fin_q;
        remainder <= fin_r;
      end
    end
  end

  // Datapath registers: only meaningful while RUN, so no reset
  always_ff @(posedge clk) begin
    if (accept || state == RUN) begin
      r_q <= r_nxt[WIDTH-1:0];
      q_q <= q_nxt;
    end
    if (accept) begin
      d_q <= den_in;
`ifdef CLA_DIV_SIGNED_EN
      q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg <= dividend[WIDTH-1];
`endif
    end
  end

endmodule

// File: tb/tb_cla_restoring_divider.sv
// Directed self-checking bench for cla_restoring_divider (WIDTH = 32).
module tb_cla_restoring_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  cla_restoring_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present operands in IDLE and take the accepting edge; inputs are then scrambled
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Called one edge after accept; counts edges from the accepting edge
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic check_result(input string tag, input logic [31:0] q, input logic [31:0] r,
                              input logic dbz);
    chk({tag, "_quotient"}, quotient, q);
    chk({tag, "_remainder"}, remainder, r);
    chk({tag, "_div_by_zero"}, div_by_zero, dbz);
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after_handshake", {out_valid, in_ready}, 2'b01);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic dbz,
                        input int lat);
    issue(a, b);
    wait_done(tag, lat);
    check_result(tag, q, r, dbz);
    handshake();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    check_result("reset", 32'h0, 32'h0, 1'b0);

    run_op("div_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
    run_op("div_by_zero", 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1);
    run_op("div_0_5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 32);
    run_op("div_max_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32);

    // Back-to-back with in_valid held high; operands changed mid-run must be ignored
    dividend = 32'hFFFFFFFF;
    divisor  = 32'd1;
    in_valid = 1'b1;
    tick();
    dividend = 32'd5;
    divisor  = 32'd9;
    chk("busy_in_ready", in_ready, 0);
    wait_done("div_ffffffff_1", 32);
    check_result("div_ffffffff_1", 32'hFFFFFFFF, 32'h0, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    wait_done("div_5_9", 32);
    check_result("div_5_9", 32'd0, 32'd5, 1'b0);
    handshake();

    // Backpressure: result held stable for 5 cycles, released on the 6th
    issue(32'd1000, 32'd7);
    wait_done("div_1000_7", 32);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      check_result("bp_hold", 32'd142, 32'd6, 1'b0);
      tick();
    end
    handshake();
    chk("bp_result_after", quotient, 32'd142);

    // Reset in the middle of a run abandons it
    issue(32'd1000, 32'd3);
    repeat (9) tick();
    chk("mid_run_out_valid", out_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    check_result("rst_mid", 32'h0, 32'h0, 1'b0);
    repeat (40) begin
      chk("rst_no_partial", out_valid, 0);
      tick();
    end
    run_op("div_9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32);

`ifdef CLA_DIV_SIGNED_EN
    run_op("s_m7_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 32);
    run_op("s_7_m2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 32);
    run_op("s_overflow", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 32);
    run_op("s_div_zero", 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1);
`else
    run_op("u_msb_by_max", 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 32);
    run_op("u_big_by_2", 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0, 32);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
